fp16_addsub_seq: RTL and testbench

- Multi-cycle sequencer for IEEE-754 binary16 add/subtract.
- Unpacks both operands, resolves special cases, and aligns the smaller operand by one bit per cycle.
- Performs the effective magnitude add/sub, normalizes one bit per cycle, rounds to nearest-even, then presents Q and FLAGS.
- Sits between the half-precision issue logic and the FP result writeback; one operation in flight at a time.

---
 rtl/fp16_addsub_seq.sv | 211 +++++++++++++++++++++
 tb/tb_fp16_addsub_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fp16_addsub_seq.sv
// fp16_addsub_seq: multi-cycle IEEE-754 binary16 add/subtract, one operation in flight.
// Alignment and normalization move one bit per cycle; the result is rounded to nearest-even.
module fp16_addsub_seq #(
  parameter int MAX_ALIGN = 13
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        OP,
  input  logic [15:0] IN_A,
  input  logic [15:0] IN_B,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] Q,
  output logic [4:0]  FLAGS,
  output logic        BUSY
);
  localparam int               CNT_W   = $clog2(MAX_ALIGN + 1);
  localparam logic [6:0]       MAX_D   = 7'(MAX_ALIGN);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ALIGN);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [14:0]      a_r, b_r;
  logic             sa, sb, res_sign, shift_b;
  logic [14:0]      ma, mb, rm;
  logic [5:0]       exp_r;
  logic [CNT_W-1:0] cnt;

  logic [4:0]        ea, eb, ea_eff, eb_eff;
  logic [9:0]        fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special, a_big;
  logic signed [6:0] exp_diff;
  logic [6:0]        d_abs;
  logic [CNT_W-1:0]  d_cap;
  logic [15:0]       spec_q;
  logic [4:0]        spec_flags;
  logic              mag_ge, sum_sign;
  logic [14:0]       sum_m;

  // Right shift of carry|hidden|frac|G|R|S with the lost bit folded into sticky.
  function automatic logic [14:0] shr_sticky(input logic [14:0] m);
    return {1'b0, m[14:2], m[1] | m[0]};
  endfunction

  // Returns {FLAGS, Q} from sign, working exponent and normalized working significand.
  function automatic logic [20:0] round_pack(input logic s, input logic [5:0] e,
                                             input logic [14:0] m);
    logic        rnd_up, inex;
    logic [11:0] sig;
    logic [5:0]  e_out;
    logic [15:0] q;
    logic [4:0]  fl;
    inex   = |m[2:0];
    rnd_up = m[2] & (m[1] | m[0] | m[3]);
    sig    = {1'b0, m[13:3]} + {11'b0, rnd_up};
    e_out  = e;
    if (sig[11]) begin
      sig   = sig >> 1;
      e_out = e + 6'd1;
    end
    if (e_out >= 6'd31) begin
      q  = {s, 15'h7C00};
      fl = 5'b00011;
    end else begin
      q  = {s, (sig[10] ? e_out[4:0] : 5'd0), sig[9:0]};
      fl = {2'b00, ~sig[10] & inex, 1'b0, inex};
    end
    return {fl, q};
  endfunction

  assign IN_READY  = (state == S_IDLE);
  assign OUT_VALID = (state == S_DONE);
  assign BUSY      = (state != S_IDLE);

  assign ea       = a_r[14:10];
  assign eb       = b_r[14:10];
  assign fa       = a_r[9:0];
  assign fb       = b_r[9:0];
  assign a_nan    = (ea == 5'd31) && (fa != 10'd0);
  assign b_nan    = (eb == 5'd31) && (fb != 10'd0);
  assign a_inf    = (ea == 5'd31) && (fa == 10'd0);
  assign b_inf    = (eb == 5'd31) && (fb == 10'd0);
  assign a_zero   = (a_r == 15'd0);
  assign b_zero   = (b_r == 15'd0);
  assign special  = a_nan | b_nan | a_inf | b_inf | (a_zero & b_zero);
  assign ea_eff   = (ea == 5'd0) ? 5'd1 : ea;
  assign eb_eff   = (eb == 5'd0) ? 5'd1 : eb;
  assign exp_diff = $signed({2'b00, ea_eff}) - $signed({2'b00, eb_eff});
  assign a_big    = ~exp_diff[6];
  assign d_abs    = a_big ? exp_diff : -exp_diff;
  assign d_cap    = (d_abs > MAX_D) ? MAX_CNT : d_abs[CNT_W-1:0];

  always_comb begin
    spec_q     = 16'h0000;
    spec_flags = 5'b00000;
    if (a_nan || b_nan) begin
      spec_q = 16'h7E00;
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_q     = 16'h7E00;
      spec_flags = 5'b10000;
    end else if (a_inf) begin
      spec_q = {sa, 15'h7C00};
    end else if (b_inf) begin
      spec_q = {sb, 15'h7C00};
    end else begin
      spec_q = {sa & sb, 15'h0000};
    end
  end

  always_comb begin
    mag_ge   = (ma >= mb);
    sum_m    = ma + mb;
    sum_sign = sa;
    if (sa != sb) begin
      sum_m    = mag_ge ? (ma - mb) : (mb - ma);
      sum_sign = mag_ge ? sa : sb;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (IN_VALID) state_nxt = S_UNPACK;
      S_UNPACK: begin
        if (special)                    state_nxt = S_DONE;
        else if (d_cap != {CNT_W{1'b0}}) state_nxt = S_ALIGN;
        else                            state_nxt = S_ADD;
      end
      S_ALIGN:  if (cnt == CNT_W'(1)) state_nxt = S_ADD;
      S_ADD: begin
        if (sum_m == 15'd0)                                   state_nxt = S_DONE;
        else if (sum_m[14] || (!sum_m[13] && exp_r > 6'd1))  state_nxt = S_NORM;
        else                                                  state_nxt = S_ROUND;
      end
      S_NORM:   if (rm[14] || rm[12] || exp_r == 6'd2) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_DONE;
      S_DONE:   if (OUT_READY) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    case (state)
      S_IDLE: if (IN_VALID) begin
        a_r <= IN_A[14:0];
        b_r <= IN_B[14:0];
        sa  <= IN_A[15];
        sb  <= IN_B[15] ^ OP;
      end
      S_UNPACK: begin
        ma      <= {1'b0, ea != 5'd0, fa, 3'b000};
        mb      <= {1'b0, eb != 5'd0, fb, 3'b000};
        exp_r   <= a_big ? {1'b0, ea_eff} : {1'b0, eb_eff};
        cnt     <= d_cap;
        shift_b <= a_big;
      end
      S_ALIGN: begin
        if (shift_b) mb <= shr_sticky(mb);
        else         ma <= shr_sticky(ma);
        cnt <= cnt - CNT_W'(1);
      end
      S_ADD: begin
        rm       <= sum_m;
        res_sign <= sum_sign;
      end
      S_NORM: begin
        if (rm[14]) begin
          rm    <= shr_sticky(rm);
          exp_r <= exp_r + 6'd1;
        end else begin
          rm    <= {rm[13:0], 1'b0};
          exp_r <= exp_r - 6'd1;
        end
      end
      default: ;
    endcase
  end

  // Result registers hold across IDLE and are cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q     <= 16'h0000;
      FLAGS <= 5'b00000;
    end else begin
      case (state)
        S_UNPACK: if (special) begin
          Q     <= spec_q;
          FLAGS <= spec_flags;
        end
        S_ADD: if (sum_m == 15'd0) begin
          Q     <= 16'h0000;
          FLAGS <= 5'b00000;
        end
        S_ROUND: {FLAGS, Q} <= round_pack(res_sign, exp_r, rm);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_addsub_seq.sv
// Bench for fp16_addsub_seq: directed vectors plus random operands against an exact-arithmetic model.
module tb_fp16_addsub_seq;
  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, OP, OUT_READY;
  logic [15:0] IN_A, IN_B;
  logic        IN_READY, OUT_VALID, BUSY;
  logic [15:0] Q;
  logic [4:0]  FLAGS;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fp16_addsub_seq #(.MAX_ALIGN(13)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OP(OP),
    .IN_A(IN_A), .IN_B(IN_B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Q(Q), .FLAGS(FLAGS), .BUSY(BUSY)
  );

  // Magnitude in units of 2^-24 (the smallest subnormal).
  function automatic longint mag(input logic [15:0] x);
    if (x[14:10] == 5'd0) return longint'(x[9:0]);
    return longint'({1'b1, x[9:0]}) << (int'(x[14:10]) - 1);
  endfunction

  // Exact sum, then rounded to nearest-even binary16. Returns {FLAGS, Q}.
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
    logic   sa, sb, a_nan, b_nan, a_inf, b_inf, sgn, inex;
    longint s, m, q, rem, half;
    int     sh, e;
    sa    = a[15];
    sb    = b[15] ^ op;
    a_nan = (a[14:10] == 5'd31) && (a[9:0] != 0);
    b_nan = (b[14:10] == 5'd31) && (b[9:0] != 0);
    a_inf = (a[14:10] == 5'd31) && (a[9:0] == 0);
    b_inf = (b[14:10] == 5'd31) && (b[9:0] == 0);
    if (a_nan || b_nan) return {5'b00000, 16'h7E00};
    if (a_inf && b_inf && (sa != sb)) return {5'b10000, 16'h7E00};
    if (a_inf) return {5'b00000, sa, 15'h7C00};
    if (b_inf) return {5'b00000, sb, 15'h7C00};
    s = (sa ? -mag(a) : mag(a)) + (sb ? -mag(b) : mag(b));
    if (s == 0) return (a[14:0] == 0 && b[14:0] == 0) ? {5'b00000, sa & sb, 15'h0000} : 21'h0;
    sgn = (s < 0);
    m   = sgn ? -s : s;
    if (m < 2048) return {5'b00000, sgn, m[14:0]};
    sh = 0;
    while ((m >> sh) >= 2048) sh++;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = longint'(1) << (sh - 1);
    inex = (rem != 0);
    if (rem > half || (rem == half && q[0])) q++;
    e = sh + 1;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e >= 31) return {5'b00011, sgn, 15'h7C00};
    return {4'b0000, inex, sgn, 5'(e), q[9:0]};
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                        output logic [15:0] q, output logic [4:0] fl, output int lat);
    int w;
    w = 0;
    while (!IN_READY && w < 50) begin
      @(posedge CLK); #1;
      w++;
    end
    IN_A = a; IN_B = b; OP = op; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
    q  = Q;
    fl = FLAGS;
  endtask

  task automatic retire();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; IN_VALID = 1'b0; OP = 1'b0; OUT_READY = 1'b0; IN_A = '0; IN_B = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    checks++; if (Q !== 16'h0000) begin errors++; $display("FAIL reset_q got %h want 0000", Q); end
    checks++; if (FLAGS !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", FLAGS); end
    RESET = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta [8] = '{16'h3C00, 16'h3C00, 16'h3E00, 16'h7BFF, 16'h7C00, 16'h7E00, 16'h3C00, 16'h0001};
    logic [15:0] tb [8] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h3C00, 16'h0001, 16'h0001};
    logic        top[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] tq [8] = '{16'h4000, 16'h0000, 16'h4100, 16'h7C00, 16'h7E00, 16'h7E00, 16'h3C00, 16'h0002};
    logic [4:0]  tf [8] = '{5'b00000, 5'b00000, 5'b00000, 5'b00011, 5'b10000, 5'b00000, 5'b00001, 5'b00000};
    int          tl [8] = '{5, -1, -1, -1, 2, 2, -1, -1};
    logic [15:0] q;
    logic [4:0]  fl;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], top[i], q, fl, lat);
      checks++;
      if (q !== tq[i]) begin errors++; $display("FAIL dir%0d_q %h op %b %h: got %h want %h", i, ta[i], top[i], tb[i], q, tq[i]); end
      checks++;
      if (fl !== tf[i]) begin errors++; $display("FAIL dir%0d_flags got %b want %b", i, fl, tf[i]); end
      if (tl[i] >= 0) begin
        checks++;
        if (lat != tl[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, tl[i]); end
      end
      retire();
    end
  endtask

  task automatic test_hold();
    logic [15:0] q;
    logic [4:0]  fl;
    int          lat;
    run_op(16'h4000, 16'h3C00, 1'b0, q, fl, lat);
    checks++; if (q !== 16'h4200) begin errors++; $display("FAIL hold_q got %h want 4200", q); end
    IN_A = 16'h3C00; IN_B = 16'h3C00; OP = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (Q !== 16'h4200 || FLAGS !== 5'b0 || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got q=%h flags=%b ov=%b ir=%b want 4200 00000 1 0",
                 i, Q, FLAGS, OUT_VALID, IN_READY);
      end
    end
    IN_VALID = 1'b0;
    retire();
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b want 1", IN_READY); end
  endtask

  task automatic test_reset_align();
    logic [15:0] q;
    logic [4:0]  fl;
    int          lat;
    IN_A = 16'h3C00; IN_B = 16'h0001; OP = 1'b0; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (BUSY !== 1'b1 || OUT_VALID !== 1'b0) begin errors++; $display("FAIL align_busy got busy=%b ov=%b want 1 0", BUSY, OUT_VALID); end
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b want 0", OUT_VALID); end
    checks++; if (Q !== 16'h0000) begin errors++; $display("FAIL midreset_q got %h want 0000", Q); end
    run_op(16'h3C00, 16'h3C00, 1'b0, q, fl, lat);
    checks++; if (q !== 16'h4000) begin errors++; $display("FAIL after_reset_q got %h want 4000", q); end
    retire();
  endtask

  task automatic test_random();
    logic [15:0] a, b, q;
    logic        op;
    logic [4:0]  fl;
    logic [20:0] exp_r;
    int          lat, mode;
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      a    = 16'($urandom);
      case (mode)
        0: b = 16'($urandom);
        1: b = a ^ (16'($urandom) & 16'h87FF);
        2: begin
          a[14:10] = 5'($urandom_range(0, 30));
          b        = 16'($urandom);
          b[14:10] = 5'($urandom_range(0, 30));
        end
        default: begin
          a[14:10] = 5'($urandom_range(28, 30));
          b        = a ^ (16'($urandom) & 16'h03FF);
        end
      endcase
      op    = 1'($urandom);
      exp_r = model(a, b, op);
      run_op(a, b, op, q, fl, lat);
      checks++;
      if (lat >= 100) begin errors++; $display("FAIL rand%0d_timeout got no OUT_VALID want within 100 cycles", i); end
      checks++;
      if (q !== exp_r[15:0]) begin errors++; $display("FAIL rand%0d_q %h op %b %h: got %h want %h", i, a, op, b, q, exp_r[15:0]); end
      checks++;
      if (fl !== exp_r[20:16]) begin errors++; $display("FAIL rand%0d_flags %h op %b %h: got %b want %b", i, a, op, b, fl, exp_r[20:16]); end
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_align();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
